// File: rtl/csc_decoder.sv
// CSC token stream to dense column stream expander (zero runs, data, tail padding).
// Define CSC_DEC_OVF_CHECK_EN to enable column-overflow detection on err_ovf.
module csc_decoder #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned COUNT_WIDTH = 4,
  parameter int unsigned COL_LEN     = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [COUNT_WIDTH-1:0] in_count,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_last,
  output logic                   err_ovf
);

  localparam int unsigned POS_W = $clog2(COL_LEN);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(COL_LEN - 1);

  typedef enum logic [1:0] {IDLE, ZEROS, DATA, PAD} state_t;

  state_t                 state, state_nxt;
  logic [POS_W-1:0]       pos, pos_nxt, pos_inc;
  logic [COUNT_WIDTH-1:0] zero_cnt, zero_cnt_nxt;
  logic [DATA_WIDTH-1:0]  data_q, data_nxt;
  logic                   last_q, last_nxt;
  logic                   in_shake, out_shake, at_end, ovf_beat;

  assign at_end    = (pos == POS_MAX);
  assign pos_inc   = at_end ? '0 : pos + 1'b1;
  assign in_shake  = in_valid & in_ready;
  assign out_shake = out_valid & out_ready;

`ifdef CSC_DEC_OVF_CHECK_EN
  logic err_q;

  assign ovf_beat = at_end & ((state == ZEROS) | ((state == DATA) & ~last_q));
  assign err_ovf  = err_q;

  always_ff @(posedge clock) begin
    if (reset)
      err_q <= 1'b0;
    else if (out_shake & ovf_beat)
      err_q <= 1'b1;
  end
`else
  assign ovf_beat = 1'b0;
  assign err_ovf  = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      pos      <= '0;
      zero_cnt <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      pos      <= pos_nxt;
      zero_cnt <= zero_cnt_nxt;
      data_q   <= data_nxt;
      last_q   <= last_nxt;
    end
  end

  // An overflowing DATA beat ends the token in IDLE, so it must not take a new token.
  always_comb begin
    out_valid = (state != IDLE);
    out_data  = (state == DATA) ? data_q : '0;
    out_last  = out_valid & at_end;
    unique case (state)
      IDLE:    in_ready = 1'b1;
      DATA:    in_ready = out_ready & ~last_q & ~ovf_beat;
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    pos_nxt      = pos;
    zero_cnt_nxt = zero_cnt;
    data_nxt     = data_q;
    last_nxt     = last_q;

    if (out_shake)
      pos_nxt = pos_inc;

    if (in_shake) begin
      zero_cnt_nxt = in_count;
      data_nxt     = in_data;
      last_nxt     = in_last;
      state_nxt    = (in_count != '0) ? ZEROS : DATA;
    end

    unique case (state)
      IDLE: ;
      ZEROS: begin
        if (out_shake) begin
          zero_cnt_nxt = zero_cnt - 1'b1;
          if (ovf_beat)
            state_nxt = IDLE;
          else if (zero_cnt == COUNT_WIDTH'(1))
            state_nxt = DATA;
        end
      end
      DATA: begin
        if (out_shake & ~in_shake)
          state_nxt = (ovf_beat | ~last_q | at_end) ? IDLE : PAD;
      end
      PAD: begin
        if (out_shake & at_end)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_csc_decoder.sv
// Directed-vector bench for csc_decoder; expectations follow CSC_DEC_OVF_CHECK_EN if defined.
module tb_csc_decoder;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned CL = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, in_last;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_count;
  logic          out_valid, out_ready, out_last;
  logic [DW-1:0] out_data;
  logic          err_ovf;

  csc_decoder #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .COL_LEN(CL)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_count(in_count), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .err_ovf(err_ovf)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic [DW-1:0] dat;
    logic          lst;
  } tok_t;

  tok_t          tq[$];
  logic [DW-1:0] bdat[$];
  logic          blst[$];
  int            bcyc[$];
  int            icyc[$];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_pass = 0;
  int            busy_ready = 0;
  bit            toggle_rdy = 0;
  bit            stall_chk = 0;
  bit            stalled = 0;
  logic [DW-1:0] stall_data;
  logic [DW-1:0] exp_a [16];

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One clock: drive at negedge, settle, then log handshakes that commit at the next posedge.
  task automatic cycle();
    @(negedge clock);
    out_ready = toggle_rdy ? ~out_ready : 1'b1;
    if (tq.size() != 0) begin
      in_valid = 1'b1;
      in_count = tq[0].cnt;
      in_data  = tq[0].dat;
      in_last  = tq[0].lst;
    end else begin
      in_valid = 1'b0;
      in_count = '0;
      in_data  = '0;
      in_last  = 1'b0;
    end
    #1;
    if (stall_chk && stalled) check("stall_hold", out_data, stall_data);
    stalled    = out_valid && !out_ready;
    stall_data = out_data;
    if (in_valid && in_ready) begin
      tq.delete(0);
      icyc.push_back(cyc);
    end
    if (out_valid && out_ready) begin
      bdat.push_back(out_data);
      blst.push_back(out_last);
      bcyc.push_back(cyc);
    end
    if (out_valid && in_ready) busy_ready++;
    cyc++;
  endtask

  task automatic clear();
    tq.delete(); bdat.delete(); blst.delete(); bcyc.delete(); icyc.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic run_until(input int n, input int budget, input string tag);
    int k = 0;
    while (bdat.size() < n && k < budget) begin
      cycle();
      k++;
    end
    check(tag, bdat.size(), n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    clear();
  endtask

  task automatic check_zero_tail(input string tag, input int from, input int to);
    for (int i = from; i <= to; i++)
      check($sformatf("%s_d%0d", tag, i), bdat[i], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    exp_a = '{8'h00, 8'h00, 8'h05, 8'h07, 8'h00, 8'h00, 8'h00, 8'h09,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    reset = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
    in_count = '0; in_data = '0; in_last = 1'b0;
    idle(2);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_err_ovf", err_ovf, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 1'b0;
    clear();

    // Mixed tokens with last-token padding
    tq.push_back('{4'd2, 8'h05, 1'b0});
    tq.push_back('{4'd0, 8'h07, 1'b0});
    tq.push_back('{4'd3, 8'h09, 1'b1});
    run_until(16, 60, "A_beats");
    idle(3);
    check("A_count", bdat.size(), 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("A_d%0d", i), bdat[i], exp_a[i]);
      check($sformatf("A_l%0d", i), blst[i], (i == 15) ? 1 : 0);
    end
    check("A_nobubble", bcyc[15] - bcyc[0], 15);
    check("A_latency", bcyc[0] - icyc[0], 1);
    check("A_idle", out_valid, 0);

    // All-zero column via a zero-data terminator
    clear();
    busy_ready = 0;
    tq.push_back('{4'd15, 8'h00, 1'b1});
    run_until(16, 40, "B_beats");
    idle(2);
    check("B_count", bdat.size(), 16);
    check_zero_tail("B", 0, 15);
    check("B_l14", blst[14], 0);
    check("B_l15", blst[15], 1);
    check("B_in_ready_busy", busy_ready, 0);
    check("B_in_ready_idle", in_ready, 1);

    // Back-pressure: out_ready toggling every cycle
    clear();
    toggle_rdy = 1; stall_chk = 1;
    tq.push_back('{4'd0, 8'h33, 1'b1});
    run_until(16, 80, "C_beats");
    toggle_rdy = 0; stall_chk = 0; stalled = 0;
    idle(2);
    check("C_count", bdat.size(), 16);
    check("C_d0", bdat[0], 8'h33);
    check_zero_tail("C", 1, 15);
    check("C_l0", blst[0], 0);
    check("C_l15", blst[15], 1);
    check("C_span", bcyc[15] - bcyc[0], 30);

    // Reset in the middle of padding (pos 9)
    clear();
    tq.push_back('{4'd0, 8'h55, 1'b1});
    run_until(9, 30, "D_pre_beats");
    cycle();
    reset = 1'b1;
    cycle();
    check("D_rst_out_valid", out_valid, 0);
    check("D_rst_in_ready", in_ready, 1);
    check("D_rst_err", err_ovf, 0);
    reset = 1'b0;
    clear();
    tq.push_back('{4'd0, 8'h44, 1'b1});
    run_until(16, 40, "D_beats");
    idle(2);
    check("D_d0", bdat[0], 8'h44);
    check("D_l0", blst[0], 0);
    check("D_l14", blst[14], 0);
    check("D_l15", blst[15], 1);

    // Column overflow: zero run crosses the column boundary
    clear();
    tq.push_back('{4'd10, 8'h01, 1'b0});
    tq.push_back('{4'd8, 8'h02, 1'b1});
`ifdef CSC_DEC_OVF_CHECK_EN
    run_until(16, 40, "E_beats");
    idle(4);
    check("E_count", bdat.size(), 16);
    check("E_d10", bdat[10], 8'h01);
    check("E_d15", bdat[15], 0);
    check("E_l15", blst[15], 1);
    check("E_err", err_ovf, 1);
    check("E_idle", out_valid, 0);
    check("E_tq_empty", tq.size(), 0);
    idle(3);
    check("E_err_sticky", err_ovf, 1);
`else
    run_until(32, 60, "E_beats");
    idle(2);
    check("E_count", bdat.size(), 32);
    check("E_d10", bdat[10], 8'h01);
    check("E_d15", bdat[15], 0);
    check("E_l15", blst[15], 1);
    check("E_d19", bdat[19], 8'h02);
    check("E_l19", blst[19], 0);
    check("E_l31", blst[31], 1);
    check("E_err", err_ovf, 0);
`endif
    do_reset();
    check("E_err_cleared", err_ovf, 0);

    // Two full columns back-to-back
    tq.push_back('{4'd0, 8'h11, 1'b1});
    tq.push_back('{4'd0, 8'h22, 1'b1});
    run_until(32, 70, "F_beats");
    idle(2);
    check("F_count", bdat.size(), 32);
    check("F_d0", bdat[0], 8'h11);
    check("F_d16", bdat[16], 8'h22);
    check("F_l15", blst[15], 1);
    check("F_l16", blst[16], 0);
    check("F_l31", blst[31], 1);
    check("F_gap", bcyc[16] - bcyc[15], 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
